trace_event_arbiter: RTL and testbench
======================================

// Module: trace_event_arbiter
// PURPOSE
//  Multi-source edge-event capture and scheduler for the accelerator trace monitor.
//  Detects edges on NUM_SRC monitored signals, timestamps them and holds one pending event per source.
//  Round-robin arbitrates the pending events onto one AXI4-Stream trace output.
//  Sits between the accelerator control/status signals and the trace packet FIFO/DMA.
// PARAMETERS
//  NUM_SRC    4   monitored sources, 1..255 (src_id 8'hFF is reserved)
//  TS_WIDTH   32  free-running timestamp counter width
//  CNT_WIDTH  16  dropped-event counter width
// PORTS
//  clk        in   1               single clock; all logic is on its rising edge
//  resetn     in   1               asynchronous, active-low reset
//  enable     in   1               1 = run capture; 0 = stop capture and drain
//  src_in     in   NUM_SRC         monitored levels (may be asynchronous)
//  src_mask   in   NUM_SRC         1 = source monitored; 0 = its edges are ignored
//  edge_mode  in   2               01 = rising, 10 = falling, 11 = both, 00 = none
//  m_tdata    out  TS_WIDTH+16     {ts[TS_WIDTH-1:0], src_id[7:0], 7'd0, rise}
//  m_tvalid   out  1               AXI-S valid
//  m_tready   in   1               AXI-S ready
//  busy       out  1               state != IDLE
//  overflow   out  1               sticky: an event was dropped
//  drop_cnt   out  CNT_WIDTH       dropped events; saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs are 0, pending flags clear, ts = 0, RR pointer = 0, state = IDLE.
//  Input pipeline: per source, s0 <= src_in; s1 <= s0; s2 <= s1.
//   rise = s1 & ~s2; fall = ~s1 & s2. Qualify with src_mask, edge_mode and state == RUN.
//  FSM:
//   IDLE  -> RUN when enable = 1. On this transition, clear ts, overflow and drop_cnt.
//   RUN   -> DRAIN when enable = 0. ts increments every cycle in RUN only.
//   DRAIN: no new captures; edges are ignored and not counted. ts holds.
//          -> IDLE when no flags are pending and m_tvalid = 0 (i.e. after the last handshake).
//          enable re-asserted during DRAIN takes effect only via IDLE -> RUN.
//  Capture: a qualified edge sets pend[i] and latches {ts, rise} into that source's slot.
//  Latency: src_in change sampled at edge N -> pend set at N+2 -> m_tvalid high after N+3.
//   This holds when the output is free and there is no contention.
//  Output register loads when (!m_tvalid || m_tready) and any flag is pending.
//   The winner is the first pending source after the last granted one (round-robin); its pend clears.
//   tdata/tvalid are held stable while m_tvalid & ~m_tready. Back-to-back transfers give 1 packet/cycle.
//  Simultaneous edges: each source latches the same ts; they are emitted in RR order.
//  Same-cycle grant and new edge on source i: the old event is sent and the new one is latched. No drop.
//  Edge on source i while pend[i] = 1 and it is not granted: the new event is discarded.
//   overflow <= 1; drop_cnt += 1, saturating.
//  ts wraps modulo 2^TS_WIDTH.
//  resetn low mid-transfer: m_tvalid drops immediately and all state clears. No partial packet survives.
// CONFIGURATION
//  TRACE_TS_WRAP_MARK_EN defined:
//   A ts wrap in RUN (all-ones -> 0) sets a wrap-pending flag.
//   The flag has priority over all sources and emits {ts = 0, src_id = 8'hFF, 7'd0, rise = 0}.
//   A second wrap while the flag is still pending counts as a drop.
//   DRAIN -> IDLE also waits for this flag to clear.
//  Not defined: ts wraps silently, no 8'hFF packets exist, and the wrap logic is absent.
// TESTING
//  1. edge_mode = 01, mask = 4'hF, tready = 1, src_in[2] 0->1 at edge N
//     -> one packet after N+3: src_id = 2, rise = 1, ts = (cycles since RUN) + 1.
//  2. src 0, 1, 3 rise in the same cycle, tready = 1
//     -> 3 packets on consecutive cycles, ids 0, 1, 3, identical ts.
//  3. tready = 0, three rising edges on src 1, spaced 4 cycles apart
//     -> first packet is held stable, second is pending, third is dropped: overflow = 1, drop_cnt = 1.
//     Then tready = 1 -> 2 packets are delivered.
//  4. Two pending, enable -> 0, plus an edge during DRAIN
//     -> 2 packets, the DRAIN edge is not reported, busy = 0 the cycle after the last handshake.
//  5. TS_WIDTH = 8, RUN for 300 cycles
//     -> with the macro, an 8'hFF packet with ts = 0 appears once; without it, no packet.
//  6. resetn low while m_tvalid = 1 and pending
//     -> m_tvalid = 0 and busy = 0 asynchronously; no packet appears after release until a new edge.

Source files
------------

// File: rtl/trace_event_arbiter.sv
// trace_event_arbiter: detects edges on NUM_SRC monitored levels, timestamps
// them into one pending slot per source and round-robin schedules the pending
// events onto a single AXI4-Stream trace output.
// Optional feature macro: TRACE_TS_WRAP_MARK_EN (timestamp-wrap marker packet,
// src_id 8'hFF, with priority over all sources).
module trace_event_arbiter #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned TS_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [NUM_SRC-1:0]   src_in,
  input  logic [NUM_SRC-1:0]   src_mask,
  input  logic [1:0]           edge_mode,
  output logic [TS_WIDTH+15:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 busy,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] drop_cnt
);
  localparam int unsigned IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [NUM_SRC-1:0]     s0_q, s1_q, s2_q;
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic [NUM_SRC-1:0]     pend_q, pend_d;
  logic [TS_WIDTH-1:0]    slot_ts_q [NUM_SRC];
  logic [TS_WIDTH-1:0]    slot_ts_d [NUM_SRC];
  logic [NUM_SRC-1:0]     slot_rise_q, slot_rise_d;
  logic [IDXW-1:0]        rr_q, rr_d;
  logic [TS_WIDTH+15:0]   tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

  logic [NUM_SRC-1:0]     rise_raw, fall_raw, hit;
  logic [NUM_SRC-1:0]     granted_oh, keep, drop_vec, new_vec;
  logic                   grant_vld, load, wrap_pend, wrap_drop;
  logic [IDXW-1:0]        grant_idx;
  int unsigned            scan;
  int                     ndrop;
  logic [CNT_WIDTH+8:0]   ext;

`ifdef TRACE_TS_WRAP_MARK_EN
  logic wrap_pend_q, wrap_pend_d;
  assign wrap_pend = wrap_pend_q;
`else
  assign wrap_pend = 1'b0;
`endif

  assign rise_raw = s1_q & ~s2_q;
  assign fall_raw = ~s1_q & s2_q;
  assign hit      = ((rise_raw & {NUM_SRC{edge_mode[0]}}) | (fall_raw & {NUM_SRC{edge_mode[1]}}))
                    & src_mask & {NUM_SRC{state_q == ST_RUN}};
  assign load     = (!tvalid_q || m_tready) && ((|pend_q) || wrap_pend);

  // Round-robin search: first pending source at or after rr_q
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      scan = 32'(rr_q) + k;
      if (scan >= NUM_SRC) scan = scan - NUM_SRC;
      if (!grant_vld && pend_q[IDXW'(scan)]) begin
        grant_vld = 1'b1;
        grant_idx = IDXW'(scan);
      end
    end
  end

  // Output register: load a new packet when free/draining, else clear on handshake
  always_comb begin
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    rr_d       = rr_q;
    granted_oh = '0;
    if (load) begin
      tvalid_d = 1'b1;
      if (wrap_pend) begin
        tdata_d = {{TS_WIDTH{1'b0}}, 8'hFF, 7'd0, 1'b0};
      end else if (grant_vld) begin
        tdata_d    = {slot_ts_q[grant_idx], 8'(grant_idx), 7'd0, slot_rise_q[grant_idx]};
        granted_oh = NUM_SRC'(1) << grant_idx;
        rr_d       = (32'(grant_idx) + 1 >= NUM_SRC) ? '0 : grant_idx + IDXW'(1);
      end
    end else if (m_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // Capture: a slot being granted this cycle is free to take the new edge
  always_comb begin
    keep        = pend_q & ~granted_oh;
    drop_vec    = hit & keep;
    new_vec     = hit & ~keep;
    pend_d      = keep | hit;
    slot_rise_d = (slot_rise_q & ~new_vec) | (new_vec & rise_raw);
    slot_ts_d   = slot_ts_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (new_vec[i]) slot_ts_d[i] = ts_q;
    end
  end

  // Control FSM, timestamp, wrap marker and drop accounting
  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    wrap_drop  = 1'b0;
    ext        = '0;
`ifdef TRACE_TS_WRAP_MARK_EN
    wrap_pend_d = wrap_pend_q;
    if (load) wrap_pend_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_RUN;
          ts_d       = '0;
          overflow_d = 1'b0;
          drop_cnt_d = '0;
        end
      end
      ST_RUN: begin
        ts_d = ts_q + TS_WIDTH'(1);
        if (!enable) state_d = ST_DRAIN;
`ifdef TRACE_TS_WRAP_MARK_EN
        if (ts_q == '1) begin
          if (wrap_pend_q && !load) wrap_drop = 1'b1;
          else                      wrap_pend_d = 1'b1;
        end
`endif
      end
      ST_DRAIN: begin
        if (pend_q == '0 && !tvalid_q && !wrap_pend) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ndrop = $countones(drop_vec) + int'(wrap_drop);
    if (ndrop != 0) begin
      overflow_d = 1'b1;
      ext        = {{9{1'b0}}, drop_cnt_q} + (CNT_WIDTH+9)'(ndrop);
      if (|ext[CNT_WIDTH+8:CNT_WIDTH]) drop_cnt_d = '1;
      else                             drop_cnt_d = ext[CNT_WIDTH-1:0];
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      state_q     <= ST_IDLE;
      ts_q        <= '0;
      pend_q      <= '0;
      slot_ts_q   <= '{default: '0};
      slot_rise_q <= '0;
      rr_q        <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      s0_q        <= src_in;
      s1_q        <= s0_q;
      s2_q        <= s1_q;
      state_q     <= state_d;
      ts_q        <= ts_d;
      pend_q      <= pend_d;
      slot_ts_q   <= slot_ts_d;
      slot_rise_q <= slot_rise_d;
      rr_q        <= rr_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef TRACE_TS_WRAP_MARK_EN
  // Wrap-marker pending flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wrap_pend_q <= 1'b0;
    else         wrap_pend_q <= wrap_pend_d;
  end
`endif

  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign busy     = (state_q != ST_IDLE);
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_trace_event_arbiter.sv
// Testbench for trace_event_arbiter: randomized and directed stimulus, a
// behavioural reference model producing expected packets into a queue, and a
// separate monitor popping the queue on every output handshake.
module tb_trace_event_arbiter;
  localparam int unsigned NS  = 4;
  localparam int unsigned TSW = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned DW  = TSW + 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic [NS-1:0] src_in = '0;
  logic [NS-1:0] src_mask = '0;
  logic [1:0]    edge_mode = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int ff_seen = 0;

  trace_event_arbiter #(.NUM_SRC(NS), .TS_WIDTH(TSW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .src_in(src_in),
    .src_mask(src_mask), .edge_mode(edge_mode), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .busy(busy),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int            m_state;          // 0 idle, 1 run, 2 drain
  int            m_ts;
  bit            m_pend  [NS];
  int            m_pts   [NS];
  bit            m_prise [NS];
  int            m_ptr;
  bit            m_ovalid;
  bit            m_wpend;
  bit            m_ovf;
  int            m_dcnt;
  logic [NS-1:0] hist [$];         // hist[0] = most recently sampled src_in
  logic [DW-1:0] expq [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pkt(input int ts, input int id, input bit rise);
    logic [7:0] t8, i8;
    t8 = ts[7:0];
    i8 = id[7:0];
    return {t8, i8, 7'd0, rise};
  endfunction

  task automatic mdl_reset();
    m_state = 0; m_ts = 0; m_ptr = 0; m_ovalid = 0; m_wpend = 0; m_ovf = 0; m_dcnt = 0;
    for (int i = 0; i < NS; i++) begin m_pend[i] = 0; m_pts[i] = 0; m_prise[i] = 0; end
    hist.delete();
    repeat (3) hist.push_back('0);
    expq.delete();
  endtask

  // Advance the model by one clock, using the inputs the DUT samples next edge
  task automatic mdl_step();
    logic [NS-1:0] s1, s2;
    bit any_old, old_ovalid, old_wpend, load, found;
    int nd, w;
    s1 = hist[1];
    s2 = hist[2];
    old_ovalid = m_ovalid;
    old_wpend  = m_wpend;
    any_old = 0;
    for (int i = 0; i < NS; i++) if (m_pend[i]) any_old = 1;
    nd = 0;
    w = 0;
    load = (!m_ovalid || m_tready) && (any_old || m_wpend);
    if (load) begin
      m_ovalid = 1;
      if (m_wpend) begin
        expq.push_back(pkt(0, 255, 0));
        m_wpend = 0;
      end else begin
        found = 0;
        for (int k = 0; k < NS; k++)
          if (!found && m_pend[(m_ptr + k) % NS]) begin w = (m_ptr + k) % NS; found = 1; end
        expq.push_back(pkt(m_pts[w], w, m_prise[w]));
        m_pend[w] = 0;
        m_ptr = (w + 1) % NS;
      end
    end else if (m_tready) begin
      m_ovalid = 0;
    end
    if (m_state == 1) begin
      for (int i = 0; i < NS; i++) begin
        bit r, f;
        r = s1[i] && !s2[i];
        f = !s1[i] && s2[i];
        if (src_mask[i] && ((r && edge_mode[0]) || (f && edge_mode[1]))) begin
          if (m_pend[i]) nd++;
          else begin m_pend[i] = 1; m_pts[i] = m_ts; m_prise[i] = r; end
        end
      end
`ifdef TRACE_TS_WRAP_MARK_EN
      if (m_ts == (1 << TSW) - 1) begin
        if (m_wpend) nd++;
        else m_wpend = 1;
      end
`endif
    end
    if (nd > 0) begin
      m_ovf = 1;
      m_dcnt = (m_dcnt + nd > (1 << CW) - 1) ? (1 << CW) - 1 : m_dcnt + nd;
    end
    case (m_state)
      0: if (enable) begin m_state = 1; m_ts = 0; m_ovf = 0; m_dcnt = 0; end
      1: begin m_ts = (m_ts + 1) % (1 << TSW); if (!enable) m_state = 2; end
      default: if (!any_old && !old_ovalid && !old_wpend) m_state = 0;
    endcase
    hist.push_front(src_in);
    void'(hist.pop_back());
  endtask

  task automatic check_state();
    chk("tvalid", m_tvalid, m_ovalid);
    chk("busy", busy, m_state != 0);
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_dcnt);
  endtask

  // One clock: check at negedge, step model, return 1 time unit after posedge
  task automatic tick();
    @(negedge clk);
    check_state();
    mdl_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [DW-1:0] mon_e;
  always @(negedge clk) begin
    if (resetn && m_tvalid && m_tready) begin
      if (m_tdata[15:8] == 8'hFF) ff_seen++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_packet: got %0h expected none", m_tdata);
      end else begin
        mon_e = expq.pop_front();
        chk("tdata", m_tdata, mon_e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_tdata", m_tdata, 0);
    resetn = 1'b1;

    // single rising edge on source 2
    enable = 1'b1; src_mask = 4'hF; edge_mode = 2'b01; m_tready = 1'b1;
    repeat (3) tick();
    src_in[2] = 1'b1;
    repeat (6) tick();

    // simultaneous edges on 0,1,3
    src_in = 4'b1011 | src_in;
    repeat (8) tick();

    // back-pressure: three rises on source 1, third dropped
    src_in = '0; m_tready = 1'b0;
    repeat (4) tick();
    for (int n = 0; n < 3; n++) begin
      src_in[1] = 1'b1; repeat (2) tick();
      src_in[1] = 1'b0; repeat (2) tick();
    end
    repeat (2) tick();
    chk("t3_overflow", overflow, 1);
    chk("t3_drop_cnt", drop_cnt, 1);
    m_tready = 1'b1;
    repeat (6) tick();

    // drain with pending events and an ignored edge during DRAIN
    m_tready = 1'b0;
    src_in[0] = 1'b1; src_in[3] = 1'b1;
    repeat (5) tick();
    enable = 1'b0;
    tick();
    src_in[2] = 1'b0; tick(); src_in[2] = 1'b1;
    repeat (3) tick();
    m_tready = 1'b1;
    budget = 0;
    while (m_state != 0 && budget < 20) begin tick(); budget++; end
    tick();
    chk("t4_busy", busy, 0);

    // long RUN to exercise timestamp wrap
    ff_seen = 0;
    enable = 1'b1;
    repeat (300) tick();
`ifdef TRACE_TS_WRAP_MARK_EN
    chk("t5_wrap_pkts", ff_seen, 1);
`else
    chk("t5_wrap_pkts", ff_seen, 0);
`endif

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      if ($urandom_range(0, 31) == 0) src_mask = NS'($urandom);
      if ($urandom_range(0, 31) == 0) edge_mode = 2'($urandom);
      m_tready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NS; i++) if ($urandom_range(0, 3) == 0) src_in[i] = ~src_in[i];
      tick();
    end

    // reset while a packet is held and others are pending
    enable = 1'b0; m_tready = 1'b1;
    budget = 0;
    while (m_state != 0 && budget < 40) begin tick(); budget++; end
    enable = 1'b1; m_tready = 1'b0; src_mask = 4'hF; edge_mode = 2'b11; src_in = '0;
    repeat (4) tick();
    src_in = 4'hF;
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    chk("t6_tvalid", m_tvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_drop_cnt", drop_cnt, 0);
    mdl_reset();
    src_in = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    m_tready = 1'b1;
    repeat (10) tick();
    src_in[1] = 1'b1;
    repeat (6) tick();

    // final drain
    enable = 1'b0;
    budget = 0;
    while ((m_state != 0 || expq.size() != 0) && budget < 50) begin tick(); budget++; end
    tick();
    chk("final_queue_empty", expq.size(), 0);
    chk("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
